// File: rtl/data_bus_responder_pkg.sv
// Shared bus constants, default address map and decode types for the data bus responder.
package data_bus_responder_pkg;

  localparam logic WR     = 1'b0;
  localparam logic RD     = 1'b1;
  localparam logic CS_SEL = 1'b0;

  localparam logic [31:0] MBOX_ADDR_DEF  = 32'hDFF;
  localparam logic [31:0] STAT_ADDR_DEF  = 32'hDFE;
  localparam int          RAM_DEPTH_DEF  = 256;
  localparam int          FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_RAM,
    DEC_MBOX,
    DEC_STAT
  } dec_e;

  function automatic logic [31:0] status_word(input logic ovf, input logic [7:0] cnt);
    return {ovf, 23'b0, cnt};
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data bus plus host mailbox drain port, bundled for the responder.
interface data_bus_responder_if;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        mb_valid;
  logic [31:0] mb_data;
  logic        mb_ready;
  logic        mb_overflow;

  // Mailbox handshake: a pop happens on every clk edge where mb_valid && mb_ready;
  // mb_data is stable while mb_valid is high and no pop occurs; mb_ready while empty is ignored.
  modport master (
    output addr, cs, wr_rd, data_bus_write, mb_ready,
    input  data_bus_read, mb_valid, mb_data, mb_overflow
  );

  modport slave (
    input  addr, cs, wr_rd, data_bus_write, mb_ready,
    output data_bus_read, mb_valid, mb_data, mb_overflow
  );
endinterface

// File: rtl/data_bus_responder_mbox_fifo.sv
// Synchronous mailbox FIFO; a push into a full FIFO is dropped and sets a sticky overflow flag.
module mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [PW:0]  count,
  output logic         overflow
);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A pop on the same clk frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/data_bus_responder.sv
// Responder on the cpu data bus: RAM window, mailbox FIFO with last-value readback, status word.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter logic [31:0] MBOX_ADDR  = MBOX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic                clk,
  input logic                rst,
  data_bus_responder_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int PW     = $clog2(FIFO_DEPTH);

  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] prev_addr, prev_wdata, last_mbox, rd_mux;
  logic        prev_cs, prev_wr_rd;
  logic        new_acc, commit, push, fifo_empty;
  logic [PW:0] fifo_count;
  dec_e        dec;

  // The cpu holds each access for many clks; only a deselect or a change of any bus field starts a new one.
  assign new_acc = (bus.cs == CS_SEL) &&
                   (prev_cs != CS_SEL || bus.addr != prev_addr ||
                    bus.wr_rd != prev_wr_rd || bus.data_bus_write != prev_wdata);
  assign commit  = !rst && new_acc && (bus.wr_rd == WR);
  assign push    = commit && (dec == DEC_MBOX);

  always_comb begin
    dec = DEC_NONE;
    if (bus.addr < 32'(RAM_DEPTH)) dec = DEC_RAM;
    else if (bus.addr == MBOX_ADDR) dec = DEC_MBOX;
    else if (bus.addr == STAT_ADDR) dec = DEC_STAT;
  end

  always_comb begin
    rd_mux = '0;
    case (dec)
      DEC_RAM:  rd_mux = ram[bus.addr[RAM_AW-1:0]];
      DEC_MBOX: rd_mux = last_mbox;
      DEC_STAT: rd_mux = status_word(bus.mb_overflow, 8'(fifo_count));
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && dec == DEC_RAM) ram[bus.addr[RAM_AW-1:0]] <= bus.data_bus_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cs           <= ~CS_SEL;
      prev_addr         <= '0;
      prev_wr_rd        <= RD;
      prev_wdata        <= '0;
      last_mbox         <= '0;
      bus.data_bus_read <= '0;
    end else begin
      prev_cs    <= bus.cs;
      prev_addr  <= bus.addr;
      prev_wr_rd <= bus.wr_rd;
      prev_wdata <= bus.data_bus_write;
      if (push) last_mbox <= bus.data_bus_write;
      if (bus.cs == CS_SEL && bus.wr_rd == RD) bus.data_bus_read <= rd_mux;
    end
  end

  mbox_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_mbox_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.data_bus_write),
    .pop       (bus.mb_ready),
    .head      (bus.mb_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (bus.mb_overflow)
  );

  assign bus.mb_valid = !fifo_empty;
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, mailbox, status, overflow and reset behaviour.
module tb_data_bus_responder;
  localparam logic [31:0] MBOX = 32'hDFF;
  localparam logic [31:0] STAT = 32'hDFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_val;

  data_bus_responder_if bus_if ();

  data_bus_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    bus_if.cs = 1'b0;
    bus_if.wr_rd = 1'b0;
    bus_if.addr = a;
    bus_if.data_bus_write = d;
    tick(hold);
    bus_if.cs = 1'b1;
    tick(1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.cs = 1'b0;
    bus_if.wr_rd = 1'b1;
    bus_if.addr = a;
    tick(1);
    d = bus_if.data_bus_read;
    bus_if.cs = 1'b1;
  endtask

  task automatic mb_pop();
    bus_if.mb_ready = 1'b1;
    tick(1);
    bus_if.mb_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // scoreboard: drain the FIFO and compare against the expected queue
  task automatic drain_check(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_vec({tag, "_valid"}, {31'b0, bus_if.mb_valid}, 32'd1);
      check_vec({tag, "_data"}, bus_if.mb_data, exp_q.pop_front());
      mb_pop();
    end
    check_vec({tag, "_empty"}, {31'b0, bus_if.mb_valid}, 32'd0);
  endtask

  initial begin
    bus_if.cs = 1'b1;
    bus_if.wr_rd = 1'b1;
    bus_if.addr = '0;
    bus_if.data_bus_write = '0;
    bus_if.mb_ready = 1'b0;

    // 1: reset state
    rst = 1'b1;
    tick(2);
    check_vec("rst_rdata", bus_if.data_bus_read, 32'h0);
    check_vec("rst_valid", {31'b0, bus_if.mb_valid}, 32'h0);
    check_vec("rst_mbdata", bus_if.mb_data, 32'h0);
    check_vec("rst_ovf", {31'b0, bus_if.mb_overflow}, 32'h0);
    rst = 1'b0;
    tick(1);
    bus_read(STAT, rd_val);
    check_vec("rst_stat", rd_val, 32'h0);

    // 2: RAM write held 32 clk, read back, neighbours independent
    bus_write(32'd5, 32'h1234, 32);
    bus_write(32'd6, 32'hA5A5_0F0F, 4);
    bus_read(32'd5, rd_val);
    check_vec("ram5", rd_val, 32'h1234);
    tick(3);
    check_vec("rd_hold", bus_if.data_bus_read, 32'h1234);
    bus_read(32'd6, rd_val);
    check_vec("ram6", rd_val, 32'hA5A5_0F0F);
    bus_read(32'd255, rd_val);
    bus_write(32'd255, 32'hFFFF_0001, 2);
    bus_read(32'd255, rd_val);
    check_vec("ram255", rd_val, 32'hFFFF_0001);
    bus_read(STAT, rd_val);
    check_vec("ram_no_push", rd_val, 32'h0);

    // 3: cpu result to mailbox, held 32 clk, exactly one push
    bus_write(MBOX, 32'd7997999, 32);
    check_vec("mb_valid", {31'b0, bus_if.mb_valid}, 32'd1);
    check_vec("mb_data", bus_if.mb_data, 32'd7997999);
    bus_read(STAT, rd_val);
    check_vec("mb_stat", rd_val, 32'h0000_0001);
    mb_pop();
    check_vec("mb_popped", {31'b0, bus_if.mb_valid}, 32'd0);

    // 4: nine pushes into eight entries
    for (int i = 0; i < 9; i++) begin
      bus_write(MBOX, 32'h100 + 32'(i), 3);
      if (i < 8) exp_q.push_back(32'h100 + 32'(i));
    end
    check_vec("ovf_flag", {31'b0, bus_if.mb_overflow}, 32'd1);
    bus_read(STAT, rd_val);
    check_vec("ovf_stat", rd_val, 32'h8000_0008);
    bus_read(MBOX, rd_val);
    check_vec("ovf_last", rd_val, 32'h108);
    drain_check("ovf_drain");
    bus_read(STAT, rd_val);
    check_vec("ovf_sticky", rd_val, 32'h8000_0000);

    // 5: full FIFO, push and pop on the same clk
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus_write(MBOX, 32'h200 + 32'(i), 2);
      exp_q.push_back(32'h200 + 32'(i));
    end
    bus_if.cs = 1'b0;
    bus_if.wr_rd = 1'b0;
    bus_if.addr = MBOX;
    bus_if.data_bus_write = 32'h2FF;
    bus_if.mb_ready = 1'b1;
    tick(1);
    bus_if.mb_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'h2FF);
    tick(3);
    bus_if.cs = 1'b1;
    tick(1);
    check_vec("pp_ovf", {31'b0, bus_if.mb_overflow}, 32'd0);
    bus_read(STAT, rd_val);
    check_vec("pp_stat", rd_val, 32'h0000_0008);
    drain_check("pp_drain");

    // 6: reset in the middle of a held mailbox write
    bus_if.cs = 1'b0;
    bus_if.wr_rd = 1'b0;
    bus_if.addr = MBOX;
    bus_if.data_bus_write = 32'hCAFE;
    tick(3);
    check_vec("mid_pre", {31'b0, bus_if.mb_valid}, 32'd1);
    rst = 1'b1;
    tick(1);
    check_vec("mid_rst_empty", {31'b0, bus_if.mb_valid}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check_vec("mid_repush", {31'b0, bus_if.mb_valid}, 32'd1);
    check_vec("mid_data", bus_if.mb_data, 32'hCAFE);
    tick(4);
    bus_if.cs = 1'b1;
    tick(1);
    bus_read(STAT, rd_val);
    check_vec("mid_stat", rd_val, 32'h0000_0001);
    bus_read(MBOX, rd_val);
    check_vec("mid_last", rd_val, 32'hCAFE);
    bus_read(32'h800, rd_val);
    check_vec("unmapped", rd_val, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
